// File: rtl/grf_sb.sv
// General register file with two prioritised write-back ports, forwarding read
// ports and a per-register pending-write scoreboard for the hazard unit.
module grf_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned PEND_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic [1:0]              wr_en,
    input  logic [2*ADDR_W-1:0]     wr_addr,
    input  logic [2*DATA_W-1:0]     wr_data,
    input  logic [1:0]              wr_retire,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_addr,
    output logic                    iss_ready,
    output logic [(2**ADDR_W)-1:0]  busy_vec,
    output logic                    sb_err
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned PMAX  = 2**PEND_W - 1;
    localparam int unsigned CW    = PEND_W + 2;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [PEND_W-1:0] cnt     [DEPTH];
    logic [PEND_W-1:0] eff     [DEPTH];
    logic [PEND_W-1:0] cnt_nxt [DEPTH];
    logic [1:0]        ret_cnt [DEPTH];
    logic [CW-1:0]     sum     [DEPTH];
    logic [DEPTH-1:0]  uflow;
    logic [ADDR_W-1:0] wa [2];
    logic [DATA_W-1:0] wd [2];
    logic              iss_acc;

    // Unpack write-back ports
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wa[p] = wr_addr[p*ADDR_W +: ADDR_W];
            wd[p] = wr_data[p*DATA_W +: DATA_W];
        end
    end

    // Same-cycle retires per register and the count net of those retires
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            ret_cnt[r] = '0;
            if (r != 0) begin
                if (wr_retire[0] && wa[0] == ADDR_W'(r)) ret_cnt[r] = ret_cnt[r] + 2'd1;
                if (wr_retire[1] && wa[1] == ADDR_W'(r)) ret_cnt[r] = ret_cnt[r] + 2'd1;
            end
            eff[r] = (CW'(cnt[r]) > CW'(ret_cnt[r]))
                   ? PEND_W'(CW'(cnt[r]) - CW'(ret_cnt[r])) : '0;
        end
    end

    assign iss_ready = (iss_addr == '0) || (CW'(eff[iss_addr]) < CW'(PMAX));
    assign iss_acc   = iss_en && iss_ready && (iss_addr != '0);

    // Next counter values; an over-retire clamps at zero and flags an error
    always_comb begin
        uflow = '0;
        for (int r = 0; r < DEPTH; r++) begin
            sum[r] = CW'(cnt[r]) + CW'(iss_acc && (iss_addr == ADDR_W'(r)));
            if (sum[r] < CW'(ret_cnt[r])) begin
                cnt_nxt[r] = '0;
                uflow[r]   = 1'b1;
            end else begin
                cnt_nxt[r] = PEND_W'(sum[r] - CW'(ret_cnt[r]));
            end
        end
    end

    // Read ports: zero register, then port 1, port 0, array
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rd_addr[k*ADDR_W +: ADDR_W] != '0) begin
                if (wr_en[1] && wa[1] == rd_addr[k*ADDR_W +: ADDR_W])
                    rd_data[k*DATA_W +: DATA_W] = wd[1];
                else if (wr_en[0] && wa[0] == rd_addr[k*ADDR_W +: ADDR_W])
                    rd_data[k*DATA_W +: DATA_W] = wd[0];
                else
                    rd_data[k*DATA_W +: DATA_W] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
                rd_busy[k] = (eff[rd_addr[k*ADDR_W +: ADDR_W]] != '0);
            end
        end
    end

    // Array, counters and error flag; port 1 written last so it wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
                cnt[r] <= '0;
            end
            busy_vec <= '0;
            sb_err   <= 1'b0;
        end else begin
            if (wr_en[0] && wa[0] != '0) mem[wa[0]] <= wd[0];
            if (wr_en[1] && wa[1] != '0) mem[wa[1]] <= wd[1];
            for (int r = 0; r < DEPTH; r++) begin
                cnt[r]      <= cnt_nxt[r];
                busy_vec[r] <= (cnt_nxt[r] != '0);
            end
            sb_err <= sb_err | (iss_en && !iss_ready) | (|uflow);
        end
    end

endmodule

// File: tb/tb_grf_sb.sv
// Directed vector bench for grf_sb: table of per-cycle stimulus with
// hand-computed expectations plus reset/underflow corner sequences.
module tb_grf_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_retire;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic [31:0] busy_vec;
    logic        sb_err;

    int n_cmp = 0;
    int n_bad = 0;

    grf_sb dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_retire(wr_retire), .iss_en(iss_en), .iss_addr(iss_addr),
        .iss_ready(iss_ready), .busy_vec(busy_vec), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [1:0]  ret;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0, ra1;
        logic [31:0] e_rd0, e_rd1;
        logic [1:0]  e_busy;
        logic        e_rdy;
        logic [31:0] e_bv;
        logic        e_err;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1, input logic [1:0] ret,
                         input logic ie, input logic [4:0] ia,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        wr_en     = we;
        wr_addr   = {wa1, wa0};
        wr_data   = {wd1, wd0};
        wr_retire = ret;
        iss_en    = ie;
        iss_addr  = ia;
        rd_addr   = {ra1, ra0};
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [4:0] wa1,
                                logic [31:0] wd0, logic [31:0] wd1, logic [1:0] ret,
                                logic ie, logic [4:0] ia, logic [4:0] ra0, logic [4:0] ra1,
                                logic [31:0] e_rd0, logic [31:0] e_rd1, logic [1:0] e_busy,
                                logic e_rdy, logic [31:0] e_bv, logic e_err);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1; v.ret = ret;
        v.ie = ie; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_busy = e_busy; v.e_rdy = e_rdy;
        v.e_bv = e_bv; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        // we  wa0 wa1 wd0 wd1 ret ie ia ra0 ra1 | rd0 rd1 busy rdy busy_vec err
        tbl[0]  = mk(2'b11, 5, 5, 32'h1111_1111, 32'h2222_2222, 2'b00, 0, 0, 5, 0,
                     32'h2222_2222, 32'h0, 2'b00, 1, 32'h0, 0);
        tbl[1]  = mk(2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 0, 0, 5, 5,
                     32'h2222_2222, 32'h2222_2222, 2'b00, 1, 32'h0, 0);
        tbl[2]  = mk(2'b11, 6, 9, 32'hA5A5_0006, 32'h9999_0009, 2'b00, 0, 0, 6, 9,
                     32'hA5A5_0006, 32'h9999_0009, 2'b00, 1, 32'h0, 0);
        tbl[3]  = mk(2'b01, 6, 0, 32'h0000_0066, 32'h0, 2'b00, 0, 0, 6, 9,
                     32'h0000_0066, 32'h9999_0009, 2'b00, 1, 32'h0, 0);
        tbl[4]  = mk(2'b01, 9, 0, 32'h0000_1234, 32'h0, 2'b00, 0, 0, 9, 6,
                     32'h0000_1234, 32'h0000_0066, 2'b00, 1, 32'h0, 0);
        tbl[5]  = mk(2'b11, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11, 1, 0, 0, 0,
                     32'h0, 32'h0, 2'b00, 1, 32'h0, 0);
        tbl[6]  = mk(2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 0, 0, 0, 9,
                     32'h0, 32'h0000_1234, 2'b00, 1, 32'h0, 0);
        tbl[7]  = mk(2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 1, 7, 7, 5,
                     32'h0, 32'h2222_2222, 2'b00, 1, 32'h0, 0);
        tbl[8]  = mk(2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 1, 7, 7, 5,
                     32'h0, 32'h2222_2222, 2'b01, 1, 32'h80, 0);
        tbl[9]  = mk(2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 1, 7, 7, 5,
                     32'h0, 32'h2222_2222, 2'b01, 1, 32'h80, 0);
        tbl[10] = mk(2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 1, 7, 7, 5,
                     32'h0, 32'h2222_2222, 2'b01, 0, 32'h80, 0);
        tbl[11] = mk(2'b00, 7, 0, 32'h0, 32'h0, 2'b01, 1, 7, 7, 5,
                     32'h0, 32'h2222_2222, 2'b01, 1, 32'h80, 1);
        tbl[12] = mk(2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 0, 7, 7, 5,
                     32'h0, 32'h2222_2222, 2'b01, 0, 32'h80, 1);
        tbl[13] = mk(2'b00, 0, 7, 32'h0, 32'h0, 2'b10, 0, 7, 7, 5,
                     32'h0, 32'h2222_2222, 2'b01, 1, 32'h80, 1);
        tbl[14] = mk(2'b01, 7, 0, 32'h0000_0077, 32'h0, 2'b01, 0, 7, 7, 5,
                     32'h0000_0077, 32'h2222_2222, 2'b01, 1, 32'h80, 1);
        tbl[15] = mk(2'b00, 7, 0, 32'h0, 32'h0, 2'b01, 0, 7, 7, 5,
                     32'h0000_0077, 32'h2222_2222, 2'b00, 1, 32'h80, 1);
        tbl[16] = mk(2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 0, 7, 7, 5,
                     32'h0000_0077, 32'h2222_2222, 2'b00, 1, 32'h0, 1);

        reset = 1'b1;
        idle();
        #2;
        chk("async_reset_busy_vec", busy_vec, 32'h0);
        chk("async_reset_sb_err", 32'(sb_err), 32'h0);
        do_reset();

        // Zeroed array and scoreboard on every address, both ports
        for (int a = 0; a < 32; a++) begin
            drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 5'(a), 5'(a), 5'(a));
            #1;
            chk($sformatf("rst_rd0[%0d]", a), rd_data[31:0], 32'h0);
            chk($sformatf("rst_rd1[%0d]", a), rd_data[63:32], 32'h0);
            chk($sformatf("rst_busy[%0d]", a), 32'(rd_busy), 32'h0);
            chk($sformatf("rst_rdy[%0d]", a), 32'(iss_ready), 32'h1);
        end
        chk("rst_busy_vec", busy_vec, 32'h0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1, tbl[i].ret,
                  tbl[i].ie, tbl[i].ia, tbl[i].ra0, tbl[i].ra1);
            #1;
            chk($sformatf("v%0d_rd0", i), rd_data[31:0], tbl[i].e_rd0);
            chk($sformatf("v%0d_rd1", i), rd_data[63:32], tbl[i].e_rd1);
            chk($sformatf("v%0d_busy", i), 32'(rd_busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d_rdy", i), 32'(iss_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_busy_vec", i), busy_vec, tbl[i].e_bv);
            chk($sformatf("v%0d_err", i), 32'(sb_err), 32'(tbl[i].e_err));
        end

        // Double retire to r3 with one pending write clamps and flags
        do_reset();
        #1;
        chk("uf_err_cleared", 32'(sb_err), 32'h0);
        chk("uf_bv_cleared", busy_vec, 32'h0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 5'd3, 5'd3, 5'd0);
        @(negedge clk);
        drive(2'b00, 5'd3, 5'd3, 32'h0, 32'h0, 2'b11, 1'b0, 5'd3, 5'd3, 5'd0);
        #1;
        chk("uf_bv_before", busy_vec, 32'h8);
        chk("uf_rd_busy", 32'(rd_busy), 32'h0);
        chk("uf_rdy", 32'(iss_ready), 32'h1);
        chk("uf_err_before", 32'(sb_err), 32'h0);
        @(negedge clk);
        idle();
        rd_addr = {5'd0, 5'd3};
        #1;
        chk("uf_err_after", 32'(sb_err), 32'h1);
        chk("uf_bv_after", busy_vec, 32'h0);
        chk("uf_rd_busy_after", 32'(rd_busy), 32'h0);

        // Asynchronous reset between edges with r4 live and cnt[4] = 2
        do_reset();
        drive(2'b01, 5'd4, 5'd0, 32'h55, 32'h0, 2'b00, 1'b1, 5'd4, 5'd4, 5'd0);
        @(negedge clk);
        drive(2'b00, 5'd0, 5'd2, 32'h0, 32'h0, 2'b10, 1'b1, 5'd4, 5'd4, 5'd0);
        @(negedge clk);
        idle();
        rd_addr  = {5'd0, 5'd4};
        iss_addr = 5'd4;
        #1;
        chk("ar_rd_before", rd_data[31:0], 32'h55);
        chk("ar_bv_before", busy_vec, 32'h10);
        chk("ar_err_before", 32'(sb_err), 32'h1);
        chk("ar_busy_before", 32'(rd_busy), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_rd_now", rd_data[31:0], 32'h0);
        chk("ar_bv_now", busy_vec, 32'h0);
        chk("ar_err_now", 32'(sb_err), 32'h0);
        chk("ar_busy_now", 32'(rd_busy), 32'h0);
        chk("ar_rdy_now", 32'(iss_ready), 32'h1);
        iss_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(2'b00, 5'd4, 5'd0, 32'h0, 32'h0, 2'b01, 1'b0, 5'd4, 5'd4, 5'd0);
        #1;
        chk("ar_bv_discard", busy_vec, 32'h0);
        @(negedge clk);
        idle();
        #1;
        chk("ar_retire_after_reset_err", 32'(sb_err), 32'h1);
        chk("ar_retire_after_reset_bv", busy_vec, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grf_sb.md
# grf_sb

Parametrised general register file with integrated write-back scoreboard for the pipelined CPU core. It provides NRD combinational read ports with same-cycle write forwarding and two write-back ports with fixed priority. A per-register pending-write counter lets the hazard unit detect in-flight writes without keeping its own tracking. It replaces the single-write, two-read register file in the decode stage.

## Interface

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W.
- NRD, 2, number of read ports (1..4).
- PEND_W, 2, pending-counter width; PMAX = 2**PEND_W - 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  read data, same slicing.
- rd_busy  out  NRD  pending-write flag per read port.
- wr_en  in  2  write enables; bit 1 = younger instruction.
- wr_addr  in  2*ADDR_W  write addresses.
- wr_data  in  2*DATA_W  write data.
- wr_retire  in  2  decrement that port's target pending counter (independent of wr_en).
- iss_en  in  1  issue: an instruction targeting iss_addr enters the pipeline.
- iss_addr  in  ADDR_W  issue destination.
- iss_ready  out  1  issue is accepted this cycle.
- busy_vec  out  DEPTH  bit r = pending counter of register r is non-zero (registered view).
- sb_err  out  1  sticky scoreboard error.

## Operation

- Register 0 is hard zero:
  - Writes, issues and retires to address 0 are ignored.
  - Reads of address 0 return 0 and rd_busy 0.
  - busy_vec[0] is always 0.
- Write, per port p with wr_en[p] and addr ≠ 0: the register takes wr_data[p] at the clock edge.
  - If both ports write the same address, port 1 wins.
- Read, per port k, combinational, in priority order:
  - addr 0 → 0;
  - else port 1 writing the same address → wr_data[1];
  - else port 0 writing the same address → wr_data[0];
  - else stored value.
- Pending counter cnt[r] (PEND_W bits) is updated at each edge:
  - +1 for an accepted issue to r.
  - −1 for each wr_retire[p] targeting r. Both ports retiring the same r gives −2.
  - Issue and retire to the same r in one cycle apply the net change.
- rd_busy[k] = (cnt[addr] − same-cycle retires to addr) ≠ 0. Same-cycle issues are not counted.
- iss_ready = (iss_addr == 0) OR (cnt[iss_addr] − same-cycle retires to iss_addr) < PMAX.
- iss_en with iss_ready = 0:
  - The issue is dropped (cnt unchanged).
  - sb_err is set.
- Underflow: a retire to a register whose net count would go below 0 clamps that counter at 0 and sets sb_err.
- sb_err is cleared only by reset.

## Timing

- Reset (asynchronous, immediate):
  - All registers 0, all cnt 0.
  - busy_vec 0, sb_err 0.
  - rd_data reflects the zeroed array; iss_ready 1.
- Releasing reset takes effect at the next rising edge. Operations in the reset cycle are discarded.
- Reset mid-operation discards all pending counts; subsequent retires underflow-clamp and set sb_err.
- Read latency is 0 cycles (combinational). A write is visible through forwarding in the same cycle and from the array on the following cycle.
- Counter latency is 1 cycle: busy_vec updates at the edge after an issue or retire. rd_busy and iss_ready include same-cycle retires.
- There are no multi-cycle operations and no internal state machine beyond the counters and sb_err.

## Test plan

- Reset, then read all addresses on all ports → rd_data 0, rd_busy 0, busy_vec 0, iss_ready 1.
- Dual write, same address:
  - Cycle 1: wr_en=2'b11, both addr 5, data0=0x1111_1111, data1=0x2222_2222, rd_addr=5 → rd_data=0x2222_2222 in-cycle.
  - Cycle 2: wr_en=0 → rd_data=0x2222_2222 from the array.
- Write to address 0 with data 0xDEAD_BEEF, issue to 0, retire to 0 → reads of 0 return 0, busy_vec[0]=0, sb_err=0.
- Pending limit, PEND_W=2:
  - Issue to r7 three times → busy_vec[7]=1; fourth issue sees iss_ready=0, is dropped, and sb_err=1.
  - Retire to r7 while iss_en to r7 in the same cycle → iss_ready=1; count stays 3.
- Retire both ports to r3 with cnt=1 → cnt clamps to 0, rd_busy 0, sb_err=1.
- Assert reset asynchronously between edges with cnt[4]=2 and r4=0x55 → r4, busy_vec and sb_err read 0 immediately, before the next edge.
